// File: rtl/lcm_seq.sv
// -----------------------------------------------------------------------------
// lcm_seq -- sequential least-common-multiple unit.
//
// Two running multiples of the operands are stepped upward, one addition per
// clock, always advancing whichever is smaller, until the two meet. The
// meeting value is LCM(a,b). A zero operand short-circuits to a result of 0.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operand pair on a/b is valid
//   in_ready   block can accept an operand pair (high only in IDLE)
//   a, b       unsigned operands, WIDTH bits
//   out_valid  result on c/iters is valid
//   out_ready  consumer accepts the result
//   c          LCM(a,b), 2*WIDTH bits
//   iters      number of additions performed for the current result
// -----------------------------------------------------------------------------
module lcm_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] c,
    output logic [2*WIDTH-1:0] iters
);

    localparam int RW = 2 * WIDTH;
    localparam logic [RW-1:0] ONE = RW'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state, state_next;
    logic [RW-1:0] ra, rb;   // latched operands, zero-extended
    logic [RW-1:0] ma, mb;   // running multiples of ra and rb

    logic accept;
    logic consume;
    logic zero_op;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;
    assign zero_op = (a == '0) || (b == '0);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_next = zero_op ? DONE : CALC;
                end
            end
            CALC: begin
                if (ma == mb) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Returning to IDLE first means a new pair can never be taken
                // on the same edge that the result is consumed.
                if (consume) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath. LCM <= a*b < 2^RW, so none of the additions can overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            ma    <= '0;
            mb    <= '0;
            c     <= '0;
            iters <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ra    <= {{WIDTH{1'b0}}, a};
                        rb    <= {{WIDTH{1'b0}}, b};
                        ma    <= {{WIDTH{1'b0}}, a};
                        mb    <= {{WIDTH{1'b0}}, b};
                        iters <= '0;
                        // A zero operand has its result ready immediately;
                        // otherwise c keeps the previous result until CALC ends.
                        if (zero_op) begin
                            c <= '0;
                        end
                    end
                end
                CALC: begin
                    if (ma == mb) begin
                        c <= ma;
                    end else if (ma < mb) begin
                        ma    <= ma + ra;
                        iters <= iters + ONE;
                    end else begin
                        mb    <= mb + rb;
                        iters <= iters + ONE;
                    end
                end
                default: ;  // DONE holds c and iters stable under backpressure
            endcase
        end
    end

endmodule

// File: doc/lcm_seq.md
Name: lcm_seq

Overview:
- Sequential least-common-multiple unit; the additive counterpart of the team's combinational subtractive GCD block.
- Accepts an operand pair over a valid/ready handshake.
- Steps two running multiples upward by repeated addition, one addition per clock, until they meet.
- Returns the LCM over a second valid/ready handshake. Used wherever the datapath needs a common period of two small counts.

Parameters:
- WIDTH, 4, operand width in bits; the result is 2*WIDTH bits wide.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair on a/b is valid
- in_ready  output  1  block can accept an operand pair (high only in IDLE)
- a  input  WIDTH  first operand, unsigned
- b  input  WIDTH  second operand, unsigned
- out_valid  output  1  result c is valid
- out_ready  input  1  consumer accepts the result
- c  output  2*WIDTH  LCM(a,b), unsigned
- iters  output  2*WIDTH  count of additions performed for the current result

Behaviour:
- Reset (async, any state):
  - state=IDLE, in_ready=1, out_valid=0, c=0, iters=0.
  - Internal ma, mb, ra, rb cleared.
  - An in-flight operation is discarded; no result is emitted.
- Internal registers:
  - ra, rb: latched operands, zero-extended to 2*WIDTH.
  - ma, mb: running multiples, 2*WIDTH bits.
  - Width rule: LCM ≤ a*b < 2^(2*WIDTH), so no addition ever overflows. No saturation or wrap logic is required.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch ra=a, rb=b, ma=a, mb=b, iters=0.
  - If a==0 or b==0: c=0, go to DONE.
  - Otherwise go to CALC.
- State CALC (in_ready=0), one action per edge:
  - ma==mb: c=ma, go to DONE.
  - ma<mb: ma=ma+ra, iters=iters+1.
  - ma>mb: mb=mb+rb, iters=iters+1.
  - in_valid is ignored while in CALC.
- State DONE:
  - out_valid=1; c and iters held stable.
  - On out_valid&&out_ready at an edge: out_valid=0, go to IDLE.
  - While out_ready=0, c, iters and out_valid stay unchanged (backpressure), indefinitely.
- Latency, with the accept edge as E0:
  - Nonzero operands needing N additions: out_valid rises after edge E(N+1).
  - Zero operand: out_valid rises after E0.
- A new operand pair cannot be accepted in the same edge that a result is consumed. Earliest next accept is the edge after the DONE→IDLE transition, so throughput is at most one result per N+3 cycles.
- c and iters retain their last values after consumption until the next result is written.
- Edge cases:
  - a==b nonzero: N=0, result = a.
  - a==1 or b==1: result = the other operand.

Test Plan:
- Normal operands: reset, then a=8, b=6 with in_valid=1, out_ready=1 → accepted at E0; N=5; out_valid=1 after E6 with c=24, iters=5; out_valid drops next edge, in_ready returns.
- Maximum result: a=15, b=14 → c=210 (8'hD2), no overflow. Then a=15, b=7 → c=105.
- Zero operand: a=0, b=5 → out_valid after E0, c=0, iters=0. Then a=9, b=0 → c=0.
- Equal and unit operands: a=b=7 → c=7, iters=0, out_valid after E1. Then a=1, b=13 → c=13.
- Backpressure: out_ready held 0 for 10 cycles after out_valid → c, iters and out_valid stable; in_ready=0 and in_valid pulses ignored. Release → single transfer, then IDLE.
- Reset mid-operation: rst asserted asynchronously during CALC of a=15, b=14 → outputs go immediately to reset values, no result emitted. After release, a=4, b=6 gives c=12.
